// File: rtl/master_out_port.sv
// Serial master port: sends an address LSB-first on tx_addr, then for writes one or
// more data words LSB-first on tx_data, pacing word boundaries on slave_ready.
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [12:0]           burst,
    input  logic                  slave_ready,
    output logic                  tx_addr,
    output logic                  tx_data,
    output logic                  master_valid,
    output logic                  data_req,
    output logic                  tx_done,
    output logic                  busy
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_READY, ADDR, DATA, BURST_GAP, DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_sh, addr_sh_nxt;
    logic [DATA_WIDTH-1:0] data_sh, data_sh_nxt;
    logic [DATA_WIDTH-1:0] word_q, word_q_nxt;
    logic [DATA_WIDTH-1:0] word_src;
    logic [12:0]           remaining, remaining_nxt;
    logic                  is_write, is_write_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                  tx_addr_nxt, tx_data_nxt, master_valid_nxt;
    logic                  data_req_nxt, tx_done_nxt, busy_nxt;

    always_comb begin
        state_nxt        = state;
        addr_sh_nxt      = addr_sh;
        data_sh_nxt      = data_sh;
        word_q_nxt       = word_q;
        remaining_nxt    = remaining;
        is_write_nxt     = is_write;
        bit_cnt_nxt      = bit_cnt;
        tx_addr_nxt      = 1'b0;
        tx_data_nxt      = 1'b0;
        master_valid_nxt = master_valid;
        data_req_nxt     = 1'b0;
        tx_done_nxt      = 1'b0;
        // The word requested by data_req is on data_in during that cycle only.
        word_src         = data_req ? data_in : word_q;

        case (state)
            IDLE: begin
                if (start && (read_en ^ write_en)) begin
                    state_nxt        = WAIT_READY;
                    addr_sh_nxt      = addr_in;
                    word_q_nxt       = data_in;
                    remaining_nxt    = (burst == 13'd0) ? 13'd1 : burst;
                    is_write_nxt     = write_en;
                    master_valid_nxt = 1'b1;
                end
            end
            WAIT_READY: begin
                if (slave_ready) begin
                    state_nxt   = ADDR;
                    tx_addr_nxt = addr_sh[0];
                    addr_sh_nxt = addr_sh >> 1;
                    bit_cnt_nxt = CNT_W'(1);
                end
            end
            ADDR: begin
                if (bit_cnt == CNT_W'(ADDR_WIDTH)) begin
                    if (is_write) begin
                        state_nxt   = DATA;
                        tx_data_nxt = word_q[0];
                        data_sh_nxt = word_q >> 1;
                        bit_cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt        = DONE;
                        tx_done_nxt      = 1'b1;
                        master_valid_nxt = 1'b0;
                        bit_cnt_nxt      = '0;
                    end
                end else begin
                    tx_addr_nxt = addr_sh[0];
                    addr_sh_nxt = addr_sh >> 1;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                    bit_cnt_nxt   = '0;
                    remaining_nxt = remaining - 13'd1;
                    if (remaining == 13'd1) begin
                        state_nxt        = DONE;
                        tx_done_nxt      = 1'b1;
                        master_valid_nxt = 1'b0;
                    end else begin
                        state_nxt    = BURST_GAP;
                        data_req_nxt = 1'b1;
                    end
                end else begin
                    tx_data_nxt = data_sh[0];
                    data_sh_nxt = data_sh >> 1;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            BURST_GAP: begin
                if (data_req) word_q_nxt = data_in;
                if (slave_ready) begin
                    state_nxt   = DATA;
                    tx_data_nxt = word_src[0];
                    data_sh_nxt = word_src >> 1;
                    bit_cnt_nxt = CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt        = IDLE;
                master_valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_sh      <= '0;
            data_sh      <= '0;
            word_q       <= '0;
            remaining    <= '0;
            is_write     <= 1'b0;
            bit_cnt      <= '0;
            tx_addr      <= 1'b0;
            tx_data      <= 1'b0;
            master_valid <= 1'b0;
            data_req     <= 1'b0;
            tx_done      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr_sh      <= addr_sh_nxt;
            data_sh      <= data_sh_nxt;
            word_q       <= word_q_nxt;
            remaining    <= remaining_nxt;
            is_write     <= is_write_nxt;
            bit_cnt      <= bit_cnt_nxt;
            tx_addr      <= tx_addr_nxt;
            tx_data      <= tx_data_nxt;
            master_valid <= master_valid_nxt;
            data_req     <= data_req_nxt;
            tx_done      <= tx_done_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: doc/master_out_port.md
MASTER_OUT_PORT -- requirements
Module: master_out_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the serialized address length in bits.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the serialized data word length in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request one transaction when high in IDLE.
REQ-006 read_en  input  1  SHALL select a read transaction (address only).
REQ-007 write_en  input  1  SHALL select a write transaction (address then data).
REQ-008 addr_in  input  ADDR_WIDTH  SHALL carry the target address, latched on accepted start.
REQ-009 data_in  input  DATA_WIDTH  SHALL carry the write word, latched on accepted start and on each burst gap.
REQ-010 burst  input  13  SHALL carry the number of data words per write, latched on accepted start.
REQ-011 slave_ready  input  1  SHALL indicate that the slave can accept serial bits.
REQ-012 tx_addr  output  1  SHALL carry address bits serially, LSB first.
REQ-013 tx_data  output  1  SHALL carry data bits serially, LSB first.
REQ-014 master_valid  output  1  SHALL be high from accepted start until DONE.
REQ-015 data_req  output  1  SHALL pulse for one cycle to request the next burst word on data_in.
REQ-016 tx_done  output  1  SHALL pulse for one cycle at transaction end.
REQ-017 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The block SHALL use states IDLE, WAIT_READY, ADDR, DATA, BURST_GAP and DONE; all outputs SHALL be registered.
REQ-019 IDLE: start=1 with exactly one of read_en/write_en SHALL latch addr_in, data_in, burst and the op, then go to WAIT_READY with master_valid=1.
REQ-020 IDLE: start with both or neither enable SHALL be ignored; state and outputs SHALL stay unchanged.
REQ-021 A latched burst of 0 SHALL be treated as 1.
REQ-022 WAIT_READY: the block SHALL hold until slave_ready=1 is sampled, then enter ADDR with tx_addr=addr bit 0.
REQ-023 ADDR: the block SHALL drive one address bit per cycle for ADDR_WIDTH cycles, LSB first.
REQ-024 ADDR end: a read SHALL go to DONE; a write SHALL go to DATA with tx_data=word bit 0.
REQ-025 DATA: the block SHALL drive one data bit per cycle for DATA_WIDTH cycles, LSB first, and decrement the remaining-word count after the last bit.
REQ-026 DATA end: remaining=0 SHALL go to DONE; otherwise the block SHALL go to BURST_GAP and assert data_req in the first gap cycle only.
REQ-027 BURST_GAP: data_in SHALL be latched at the end of the data_req cycle; the block SHALL stay in BURST_GAP while slave_ready=0 and enter DATA on the first cycle it samples slave_ready=1.
REQ-028 The address SHALL be sent once per transaction; it SHALL NOT be resent per burst word.
REQ-029 slave_ready SHALL be ignored during ADDR and DATA.
REQ-030 tx_addr and tx_data SHALL be 0 outside ADDR and DATA respectively.
REQ-031 DONE SHALL last one cycle: tx_done=1, master_valid=0, next state IDLE.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 Latency: with start sampled at edge k and slave_ready=1, address bits SHALL appear after edges k+1..k+12.
REQ-034 Latency: for a single-word write, data bits SHALL appear after edges k+13..k+20 and tx_done after edge k+21.
REQ-035 Latency: for a read, tx_done SHALL appear after edge k+13.

Reset
REQ-036 reset=0 SHALL immediately force state IDLE, counters 0, and all outputs 0, independent of clk.
REQ-037 Reset asserted mid-transaction SHALL abort it without a tx_done pulse.
REQ-038 After reset release, the first accepted start SHALL behave as from power-up.

Verification
REQ-039 Write, addr 0xA5C, data 0x3C, burst 1, slave_ready=1 -> tx_addr 0,0,1,1,1,0,1,0,0,1,0,1; tx_data 0,0,1,1,1,1,0,0; tx_done after edge k+21.
REQ-040 Read, addr 0x001 -> tx_addr 1 followed by eleven 0s; tx_data stays 0; data_req never asserts; tx_done after edge k+13.
REQ-041 Write, burst 3, words 0x11/0x22/0x33 supplied on data_req -> exactly 2 data_req pulses; 24 data bits serialized in order; one address phase.
REQ-042 slave_ready held 0 for 5 cycles after start -> master_valid=1, tx_addr=0, busy=1 throughout; ADDR starts on the edge that samples slave_ready=1.
REQ-043 reset=0 on the 4th DATA bit -> all outputs 0 immediately, no tx_done; a new write after release completes normally.
REQ-044 start with read_en=write_en=1 -> ignored, busy stays 0; write with burst=0 -> exactly one 8-bit word sent.
